// File: rtl/sram_burst_controller.sv
// Burst controller for an asynchronous SRAM: accepts a read or write request,
// checks the byte address against the mapped window, then moves BURST_LEN words.
module sram_burst_controller #(
  parameter int          DATA_W      = 32,
  parameter int          SRAM_AW     = 17,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 5,
  parameter int          BURST_LEN   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          read_en,
  input  logic                          write_en,
  input  logic [31:0]                   address,
  input  logic [BURST_LEN*DATA_W-1:0]   write_data,
  output logic                          ready,
  output logic [BURST_LEN*DATA_W-1:0]   read_data,
  output logic                          read_valid,
  output logic                          addr_err,
  output logic [SRAM_AW-1:0]            SRAM_ADDR,
  inout  wire  [DATA_W-1:0]             SRAM_DQ,
  output logic                          SRAM_WE_N,
  output logic                          SRAM_OE_N,
  output logic                          SRAM_CE_N,
  output logic                          SRAM_UB_N,
  output logic                          SRAM_LB_N,
  output logic [1:0]                    dbg_state_o
);

  localparam int SHIFT = (DATA_W == 32) ? 2 : 1;
  localparam int KW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BW    = BURST_LEN * DATA_W;
  localparam logic [63:0] SRAM_TOP = (64'd1 << SRAM_AW) - 64'd1;

  // Handshake: a request is accepted on the clock edge where the FSM is in IDLE
  // with read_en or write_en high (ready is low in that cycle); ready returns high
  // in DONE, and the requester drops its strobe once the request has been taken.
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic [SRAM_AW-1:0] wa_q, wa_d;
  logic [BW-1:0]    wdata_q, wdata_d;
  logic [BW-1:0]    rdata_q, rdata_d;
  logic             is_read_q, is_read_d;
  logic             err_q, err_d;

  logic [31:0] offset;
  logic [31:0] wa_in;
  logic [63:0] last_wa;
  logic        req_bad;
  logic        last_cnt;
  logic        last_k;

  assign offset   = address - BASE_ADDR;
  assign wa_in    = offset >> SHIFT;
  assign last_wa  = {32'd0, wa_in} + 64'(BURST_LEN) - 64'd1;
  // Rejecting any burst that would run past the top word keeps bursts from wrapping.
  assign req_bad  = (address < BASE_ADDR) || (address[SHIFT-1:0] != '0) || (last_wa > SRAM_TOP);
  assign last_cnt = (cnt_q == 4'(WAIT_CYCLES - 1));
  assign last_k   = (k_q == KW'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      wa_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      is_read_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      wa_q      <= wa_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      is_read_q <= is_read_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    wa_d      = wa_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    is_read_d = is_read_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (read_en || write_en) begin
          is_read_d = read_en;
          wdata_d   = write_data;
          wa_d      = wa_in[SRAM_AW-1:0];
          err_d     = req_bad;
          cnt_d     = '0;
          k_d       = '0;
          if (req_bad)      state_d = DONE;
          else if (read_en) state_d = READ;
          else              state_d = WRITE;
        end
      end
      READ, WRITE: begin
        if (last_cnt) begin
          if (state_q == READ) rdata_d[k_q*DATA_W +: DATA_W] = SRAM_DQ;
          cnt_d = '0;
          if (last_k) begin
            k_d     = '0;
            state_d = DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready       = (state_q == IDLE) ? !(read_en || write_en) : (state_q == DONE);
  assign read_data   = rdata_q;
  assign read_valid  = (state_q == DONE) && is_read_q && !err_q;
  assign addr_err    = (state_q == DONE) && err_q;
  assign SRAM_ADDR   = (state_q == READ || state_q == WRITE) ? wa_q + SRAM_AW'(k_q) : wa_in[SRAM_AW-1:0];
  // WE_N rises on the last cycle of each word so data is held past the write pulse.
  assign SRAM_WE_N   = !((state_q == WRITE) && !last_cnt);
  assign SRAM_OE_N   = (state_q == WRITE);
  assign SRAM_DQ     = (state_q == WRITE) ? wdata_q[k_q*DATA_W +: DATA_W] : {DATA_W{1'bz}};
  assign SRAM_CE_N   = 1'b0;
  assign SRAM_UB_N   = 1'b0;
  assign SRAM_LB_N   = 1'b0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_burst_controller.sv
// Directed bench for sram_burst_controller with an SRAM model on the tristate bus
// and an expected-read-data queue popped on each read_valid pulse.
module tb_sram_burst_controller;

  localparam int AW   = 17;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] address = 32'd1024;
  logic [63:0] write_data = '0;
  logic        ready, read_valid, addr_err;
  logic [63:0] read_data;
  logic [AW-1:0] SRAM_ADDR;
  wire  [31:0] SRAM_DQ;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:(1<<AW)-1];
  logic [63:0] exp_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          we_low_cnt = 0;

  sram_burst_controller dut (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
    .address(address), .write_data(write_data), .ready(ready),
    .read_data(read_data), .read_valid(read_valid), .addr_err(addr_err),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // SRAM model: drives the bus while OE_N is low, stores on edges with WE_N low
  assign SRAM_DQ = !SRAM_OE_N ? mem[SRAM_ADDR] : 32'bz;
  always @(posedge clk) begin
    if (!SRAM_WE_N) begin
      mem[SRAM_ADDR] <= SRAM_DQ;
      we_low_cnt     <= we_low_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input bit detailed);
    address    = a;
    write_data = d;
    write_en   = 1'b1;
    #1;
    check("wr_ready_req", ready, 1'b0);
    step();
    write_en   = 1'b0;
    address    = $urandom;
    write_data = {$urandom, $urandom};
    #1;
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) step();
      if (detailed) begin
        check("wr_addr", SRAM_ADDR, (i <= 5) ? 0 : 1);
        check("wr_we_n", SRAM_WE_N, (i % 5) == 0);
        check("wr_dq", SRAM_DQ, (i <= 5) ? d[31:0] : d[63:32]);
        check("wr_oe_n", SRAM_OE_N, 1'b1);
        check("wr_ready_busy", ready, 1'b0);
      end
    end
    step();
    check("wr_done_ready", ready, 1'b1);
    check("wr_done_state", dbg_state, 2'd3);
    check("wr_done_err", addr_err, 1'b0);
    check("wr_done_rv", read_valid, 1'b0);
    step();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [63:0] exp, input bit both,
                         input logic [AW-1:0] exp_wa);
    int c;
    int we0;
    logic [63:0] got;
    exp_q.push_back(exp);
    we0        = we_low_cnt;
    address    = a;
    read_en    = 1'b1;
    write_en   = both;
    write_data = {$urandom, $urandom};
    #1;
    check("rd_ready_req", ready, 1'b0);
    step();
    read_en  = 1'b0;
    write_en = 1'b0;
    address  = $urandom;
    #1;
    check("rd_first_addr", SRAM_ADDR, exp_wa);
    check("rd_state", dbg_state, 2'd1);
    c = 1;
    while (!read_valid && c < 40) begin
      step();
      c++;
    end
    check("rd_latency", c, 11);
    if (read_valid) begin
      check("sb_nonempty", exp_q.size() > 0, 1'b1);
      got = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
      check("rd_data", read_data, got);
      check("rd_ready_done", ready, 1'b1);
    end
    check("rd_no_we", we_low_cnt, we0);
    step();
    check("rd_valid_pulse", read_valid, 1'b0);
    check("rd_data_held", read_data, exp);
  endtask

  task automatic bad_req(input logic [31:0] a, input bit rd);
    logic [63:0] prev;
    int we0;
    prev     = read_data;
    we0      = we_low_cnt;
    address  = a;
    read_en  = rd;
    write_en = !rd;
    #1;
    check("bad_ready_req", ready, 1'b0);
    step();
    read_en  = 1'b0;
    write_en = 1'b0;
    #1;
    check("bad_state", dbg_state, 2'd3);
    check("bad_err", addr_err, 1'b1);
    check("bad_ready1", ready, 1'b1);
    check("bad_rv", read_valid, 1'b0);
    step();
    check("bad_err_pulse", addr_err, 1'b0);
    check("bad_ready2", ready, 1'b1);
    check("bad_rdata", read_data, prev);
    check("bad_no_we", we_low_cnt, we0);
  endtask

  initial begin
    logic [63:0] d;
    int wa;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE0000 | 32'(i);

    // reset state
    rst = 1'b0;
    repeat (3) step();
    check("rst_ready", ready, 1'b1);
    check("rst_rdata", read_data, 64'd0);
    check("rst_rv", read_valid, 1'b0);
    check("rst_err", addr_err, 1'b0);
    check("rst_we_n", SRAM_WE_N, 1'b1);
    check("rst_oe_n", SRAM_OE_N, 1'b0);
    check("rst_ties", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 3'b000);
    check("rst_state", dbg_state, 2'd0);
    check("rst_addr", SRAM_ADDR, 0);
    check("rst_dq_model", SRAM_DQ, 32'hC0DE0000);
    rst = 1'b1;
    step();

    // two-word write then read back
    do_write(32'd1024, {32'hBBBB0001, 32'hAAAA0000}, 1'b1);
    check("mem0", mem[0], 32'hAAAA0000);
    check("mem1", mem[1], 32'hBBBB0001);
    do_read(32'd1024, {32'hBBBB0001, 32'hAAAA0000}, 1'b0, 0);

    // read wins over write when both strobes are high
    mem[2] = 32'h22220002;
    mem[3] = 32'h33330003;
    do_read(32'd1032, {32'h33330003, 32'h22220002}, 1'b1, 2);

    // rejected requests: below base, misaligned, burst past the top
    bad_req(32'd1000, 1'b1);
    bad_req(32'd1026, 1'b0);
    bad_req(BASE + 4 * ((1 << AW) - 1), 1'b0);

    // highest legal burst start
    do_write(BASE + 4 * ((1 << AW) - 2), {32'h0F0F0F0F, 32'hF0F0F0F0}, 1'b0);
    check("mem_top0", mem[(1 << AW) - 2], 32'hF0F0F0F0);
    check("mem_top1", mem[(1 << AW) - 1], 32'h0F0F0F0F);

    // reset in the 3rd cycle of a write aborts it silently
    address    = 32'd1024;
    write_data = {32'h12345678, 32'h9ABCDEF0};
    write_en   = 1'b1;
    step();
    write_en = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check("abort_we_n", SRAM_WE_N, 1'b1);
    check("abort_ready", ready, 1'b1);
    check("abort_err", addr_err, 1'b0);
    check("abort_rv", read_valid, 1'b0);
    check("abort_state", dbg_state, 2'd0);
    check("abort_oe_n", SRAM_OE_N, 1'b0);
    rst = 1'b1;
    step();
    check("abort_err2", addr_err, 1'b0);
    check("abort_rv2", read_valid, 1'b0);

    // random write/read-back pairs
    for (int n = 0; n < 4; n++) begin
      wa = 2 * $urandom_range(4, 60);
      d  = {$urandom, $urandom};
      do_write(BASE + 4 * wa, d, 1'b0);
      do_read(BASE + 4 * wa, d, 1'b0, wa[AW-1:0]);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
